tt_um_rs_bcd2bin: RTL and testbench
===================================

TT_UM_RS_BCD2BIN -- requirements
Module: tt_um_rs_bcd2bin

Interface
REQ-001 SHALL have clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ena  input  1  tile enable; ignored by logic.
REQ-004 SHALL have ui_in  input  8  BCD operand: [7:4] tens digit, [3:0] ones digit.
REQ-005 SHALL have uio_in  input  8  [3:0] hundreds digit, [4] start; [7:5] ignored.
REQ-006 SHALL have uo_out  output  8  binary result register.
REQ-007 SHALL have uio_out  output  8  [5] busy, [6] done, [7] err; [4:0] driven 0.
REQ-008 SHALL have uio_oe  output  8  constant 8'b1110_0000.

Function
REQ-009 SHALL register start into start_q each edge; a start event is start=1 with start_q=0 (rising edge).
REQ-010 SHALL implement states IDLE and CONV, plus a 3-bit step counter.
REQ-011 IDLE: on a start event, SHALL capture the 12-bit BCD operand {H,T,O}, clear done and err, and set busy.
REQ-012 At capture, SHALL flag invalid if any digit > 9, or if the value > 255 (H>2; H=2,T>5; H=2,T=5,O>5).
REQ-013 Invalid operand: SHALL remain in IDLE, with uo_out=8'hFF, err=1, done=1, busy=0, all visible after the capture edge.
REQ-014 Valid operand: SHALL enter CONV with counter=0 and internal binary shift register=0.
REQ-015 Each CONV edge SHALL perform one reverse double-dabble step: shift {BCD,bin} right by 1, then subtract 3 from every BCD digit whose value is >= 8.
REQ-016 After the 8th step (counter=7), SHALL load uo_out with the binary result, set done=1, clear busy, and return to IDLE.
REQ-017 Latency: if the capture edge is E0, then uo_out/done SHALL be valid after edge E8, and busy SHALL be high from after E0 through E8.
REQ-018 uo_out, done and err SHALL hold their values until the next accepted start event.
REQ-019 Start events while in CONV SHALL be ignored, and start held high SHALL trigger exactly one conversion.
REQ-020 A start event in IDLE with done=1 SHALL begin a new conversion (REQ-011), clearing done on the capture edge.
REQ-021 uo_out SHALL NOT change during CONV; intermediate values stay internal.
REQ-022 Operand inputs SHALL be sampled only at the capture edge; changes during CONV SHALL have no effect.

Reset
REQ-023 rst_n=0 SHALL immediately force state=IDLE, counter=0, start_q=0, uo_out=0, busy=0, done=0, err=0, and internal registers=0.
REQ-024 Reset during CONV SHALL abort the conversion with no result delivered.
REQ-025 After rst_n rises, if start is already high, SHALL NOT see a start event until start goes low and high again.

Verification
REQ-026 H=1,T=2,O=0, start pulse -> after E8 uo_out=0x78, done=1, err=0, busy low; busy high for 8 cycles.
REQ-027 Sweep all valid operands 000..255 -> uo_out equals the decimal value each time, with 9-edge latency.
REQ-028 H=2,T=5,O=6 -> after E0 uo_out=0xFF, err=1, done=1, busy=0; and T=0xA,O=3,H=0 -> err=1.
REQ-029 Start 2,5,5, then assert rst_n=0 after E4 -> all outputs 0 immediately; a later start with 0,5,6 -> uo_out=0x38 after E8.
REQ-030 Start held high for 30 cycles with 0,9,9 -> exactly one conversion, uo_out=0x63; operand changed to 1,0,0 mid-CONV -> result still 0x63.
REQ-031 Back-to-back runs 0,0,3 then 0,3,2 (start re-pulsed when done=1) -> done drops after E0, then uo_out 0x03 then 0x20; uio_oe=0xE0 throughout.

Source files
------------

// File: rtl/tt_um_rs_bcd2bin.sv
// Three-digit BCD (000..255) to 8-bit binary converter using reverse double-dabble,
// one shift/adjust step per clock, with start edge detection and busy/done/err flags.
module tt_um_rs_bcd2bin (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   typedef enum logic {IDLE, CONV} state_t;

   state_t      state;
   logic [2:0]  step_cnt;
   logic        start_q;
   logic        start_armed;
   logic [11:0] bcd_sr;
   logic [7:0]  bin_sr;
   logic [7:0]  result_q;
   logic        busy_q;
   logic        done_q;
   logic        err_q;

   logic        start_in;
   logic        start_event;
   logic [3:0]  hundreds;
   logic [3:0]  tens;
   logic [3:0]  ones;
   logic        operand_invalid;
   logic [19:0] shifted;
   logic [11:0] bcd_next;
   logic [7:0]  bin_next;
   logic        unused;

   assign start_in = uio_in[4];
   assign hundreds = uio_in[3:0];
   assign tens     = ui_in[7:4];
   assign ones     = ui_in[3:0];
   assign unused   = &{ena, uio_in[7:5], 1'b0};

   // start_armed stays low after reset until start is seen low, so a start
   // line already held high while leaving reset cannot fire a conversion.
   assign start_event = start_in && !start_q && start_armed;

   assign operand_invalid = (hundreds > 4'd9) || (tens > 4'd9) || (ones > 4'd9) ||
                            (hundreds > 4'd2) ||
                            ((hundreds == 4'd2) && (tens > 4'd5)) ||
                            ((hundreds == 4'd2) && (tens == 4'd5) && (ones > 4'd5));

   function automatic logic [3:0] adjust(input logic [3:0] d);
      return (d >= 4'd8) ? (d - 4'd3) : d;
   endfunction

   // One reverse double-dabble step: shift the whole chain right, then pull
   // 3 out of any BCD digit that received a carried-in half from the left.
   assign shifted  = {bcd_sr, bin_sr} >> 1;
   assign bin_next = shifted[7:0];
   assign bcd_next = {adjust(shifted[19:16]), adjust(shifted[15:12]), adjust(shifted[11:8])};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         step_cnt    <= 3'd0;
         start_q     <= 1'b0;
         start_armed <= 1'b0;
         bcd_sr      <= 12'd0;
         bin_sr      <= 8'd0;
         result_q    <= 8'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         start_q <= start_in;
         if (!start_in) begin
            start_armed <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (start_event) begin
                  if (operand_invalid) begin
                     result_q <= 8'hFF;
                     err_q    <= 1'b1;
                     done_q   <= 1'b1;
                     busy_q   <= 1'b0;
                  end else begin
                     bcd_sr   <= {hundreds, tens, ones};
                     bin_sr   <= 8'd0;
                     step_cnt <= 3'd0;
                     err_q    <= 1'b0;
                     done_q   <= 1'b0;
                     busy_q   <= 1'b1;
                     state    <= CONV;
                  end
               end
            end
            CONV: begin
               bcd_sr   <= bcd_next;
               bin_sr   <= bin_next;
               step_cnt <= step_cnt + 3'd1;
               if (step_cnt == 3'd7) begin
                  result_q <= bin_next;
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign uo_out  = result_q;
   assign uio_out = {err_q, done_q, busy_q, 5'b00000};
   assign uio_oe  = 8'b1110_0000;

endmodule

// File: tb/tb_tt_um_rs_bcd2bin.sv
// Self-checking bench for tt_um_rs_bcd2bin: directed table, full valid sweep,
// random operands against an arithmetic model, and reset/start corner sequences.
module tb_tt_um_rs_bcd2bin;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int vectors;
   int miscompares;
   logic [7:0] last_out;

   typedef struct {
      logic [3:0] h;
      logic [3:0] t;
      logic [3:0] o;
      logic [7:0] exp_out;
      logic       exp_err;
   } vec_t;

   tt_um_rs_bcd2bin dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .ui_in  (ui_in),
      .uio_in (uio_in),
      .uo_out (uo_out),
      .uio_out(uio_out),
      .uio_oe (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, actual, expected, $time);
      end
   endtask

   // Model works on the decimal value, independent of any shift mechanics.
   function automatic logic modelInvalid(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
      int value;
      if (h > 9 || t > 9 || o > 9) return 1'b1;
      value = int'(h) * 100 + int'(t) * 10 + int'(o);
      return value > 255;
   endfunction

   function automatic logic [7:0] modelValue(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
      int value;
      value = int'(h) * 100 + int'(t) * 10 + int'(o);
      return value[7:0];
   endfunction

   task automatic applyStimulus(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o, input logic start);
      ui_in  = {t, o};
      uio_in = {3'b000, start, h};
   endtask

   task automatic doConversion(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
      logic       inv;
      logic [7:0] expv;
      inv  = modelInvalid(h, t, o);
      expv = inv ? 8'hFF : modelValue(h, t, o);
      @(negedge clk);
      applyStimulus(h, t, o, 1'b0);
      @(negedge clk);
      applyStimulus(h, t, o, 1'b1);
      @(posedge clk);
      #1;
      if (inv) begin
         checkOutput("inv_out", uo_out, 8'hFF);
         checkOutput("inv_err", {7'd0, uio_out[7]}, 8'd1);
         checkOutput("inv_done", {7'd0, uio_out[6]}, 8'd1);
         checkOutput("inv_busy", {7'd0, uio_out[5]}, 8'd0);
         @(negedge clk);
         applyStimulus(h, t, o, 1'b0);
      end else begin
         checkOutput("e0_busy", {7'd0, uio_out[5]}, 8'd1);
         checkOutput("e0_done", {7'd0, uio_out[6]}, 8'd0);
         checkOutput("e0_err", {7'd0, uio_out[7]}, 8'd0);
         @(negedge clk);
         applyStimulus(4'd0, 4'd0, 4'd0, 1'b0);
         for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (k < 8) begin
               checkOutput("conv_busy", {7'd0, uio_out[5]}, 8'd1);
               checkOutput("conv_hold", uo_out, last_out);
            end else begin
               checkOutput("result", uo_out, expv);
               checkOutput("end_done", {7'd0, uio_out[6]}, 8'd1);
               checkOutput("end_busy", {7'd0, uio_out[5]}, 8'd0);
               checkOutput("end_err", {7'd0, uio_out[7]}, 8'd0);
            end
         end
      end
      checkOutput("oe", uio_oe, 8'hE0);
      last_out = expv;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      last_out = 8'h00;
   endtask

   initial begin
      vec_t table_v[10];
      int   busy_cycles;

      vectors     = 0;
      miscompares = 0;
      last_out    = 8'h00;
      ena         = 1'b1;
      rst_n       = 1'b0;
      applyStimulus(4'd0, 4'd0, 4'd0, 1'b0);

      table_v[0] = '{4'd1, 4'd2, 4'd0, 8'h78, 1'b0};
      table_v[1] = '{4'd2, 4'd5, 4'd6, 8'hFF, 1'b1};
      table_v[2] = '{4'd0, 4'hA, 4'd3, 8'hFF, 1'b1};
      table_v[3] = '{4'd2, 4'd5, 4'd5, 8'hFF, 1'b0};
      table_v[4] = '{4'd0, 4'd0, 4'd0, 8'h00, 1'b0};
      table_v[5] = '{4'd0, 4'd9, 4'd9, 8'h63, 1'b0};
      table_v[6] = '{4'd2, 4'd6, 4'd0, 8'hFF, 1'b1};
      table_v[7] = '{4'd3, 4'd0, 4'd0, 8'hFF, 1'b1};
      table_v[8] = '{4'd0, 4'd0, 4'hF, 8'hFF, 1'b1};
      table_v[9] = '{4'd1, 4'd9, 4'd9, 8'hC7, 1'b0};

      #12;
      checkOutput("rst_out", uo_out, 8'h00);
      checkOutput("rst_uio", uio_out, 8'h00);
      checkOutput("rst_oe", uio_oe, 8'hE0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] directed table");
      for (int i = 0; i < 10; i++) begin
         doConversion(table_v[i].h, table_v[i].t, table_v[i].o);
         checkOutput("tbl_out", uo_out, table_v[i].exp_out);
         checkOutput("tbl_err", {7'd0, uio_out[7]}, {7'd0, table_v[i].exp_err});
      end

      $display("[TB] sweep 000..255");
      for (int v = 0; v < 256; v++) begin
         doConversion(4'(v / 100), 4'((v / 10) % 10), 4'(v % 10));
         checkOutput("sweep", uo_out, 8'(v));
      end

      $display("[TB] random operands");
      for (int i = 0; i < 60; i++) begin
         logic [11:0] r;
         r = 12'($urandom);
         if (i % 2 == 0) begin
            r = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         end
         doConversion(r[11:8], r[7:4], r[3:0]);
      end

      $display("[TB] reset during conversion");
      @(negedge clk);
      applyStimulus(4'd2, 4'd5, 4'd5, 1'b0);
      @(negedge clk);
      applyStimulus(4'd2, 4'd5, 4'd5, 1'b1);
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("abort_out", uo_out, 8'h00);
      checkOutput("abort_uio", uio_out, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(4'd2, 4'd5, 4'd5, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      checkOutput("abort_nores", uio_out, 8'h00);
      last_out = 8'h00;
      doConversion(4'd0, 4'd5, 4'd6);
      checkOutput("after_abort", uo_out, 8'h38);

      $display("[TB] start held high across reset");
      @(negedge clk);
      applyStimulus(4'd0, 4'd4, 4'd2, 1'b1);
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      last_out = 8'h00;
      busy_cycles = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         #1;
         if (uio_out[5]) busy_cycles++;
      end
      checkOutput("held_no_start", 8'(busy_cycles), 8'd0);
      checkOutput("held_out", uo_out, 8'h00);
      doConversion(4'd0, 4'd4, 4'd2);

      $display("[TB] start held high 30 cycles");
      doReset();
      @(negedge clk);
      applyStimulus(4'd0, 4'd9, 4'd9, 1'b0);
      @(negedge clk);
      applyStimulus(4'd0, 4'd9, 4'd9, 1'b1);
      busy_cycles = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk);
         #1;
         if (uio_out[5]) busy_cycles++;
         if (c == 3) applyStimulus(4'd1, 4'd0, 4'd0, 1'b1);
         if (c == 8) checkOutput("held_e8", uo_out, 8'h63);
      end
      checkOutput("held_busy_cnt", 8'(busy_cycles), 8'd8);
      checkOutput("held_final", uo_out, 8'h63);
      checkOutput("held_done", {7'd0, uio_out[6]}, 8'd1);
      last_out = 8'h63;

      $display("[TB] back-to-back");
      doConversion(4'd0, 4'd0, 4'd3);
      checkOutput("b2b_first", uo_out, 8'h03);
      doConversion(4'd0, 4'd3, 4'd2);
      checkOutput("b2b_second", uo_out, 8'h20);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
